// File: rtl/mmio_periph_bank.sv
// Memory-mapped peripheral bank: output registers, a prescaled delay timer with
// sticky expiry, and a synchronised switch port with rising-edge capture.
module mmio_periph_bank #(
  parameter int         DATA_W   = 16,
  parameter int         NUM_REGS = 4,
  parameter logic [3:0] BASE_REG = 4'h1,
  parameter logic [3:0] BASE_TMR = 4'h3,
  parameter logic [3:0] BASE_SW  = 4'h4,
  parameter int         PRESCALE = 1
) (
  input  logic                         Clock,
  input  logic                         Resetn,
  input  logic [15:0]                  ADDR,
  input  logic [DATA_W-1:0]            DOUT,
  input  logic                         W,
  input  logic [DATA_W-1:0]            SW_IN,
  output logic [DATA_W-1:0]            RDATA,
  output logic                         HIT,
  output logic [NUM_REGS*DATA_W-1:0]   REG_Q,
  output logic                         TMR_IRQ
);

  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

  logic [3:0] region;
  logic [3:0] offset;
  logic       unusedAddrBits;
  logic       regWr;
  logic       tmrWr;
  logic       swWr;

  assign region         = ADDR[15:12];
  assign offset         = ADDR[3:0];
  assign unusedAddrBits = ^ADDR[11:4];
  assign regWr          = W && (region == BASE_REG);
  assign tmrWr          = W && (region == BASE_TMR);
  assign swWr           = W && (region == BASE_SW);

  logic [DATA_W-1:0] bank_q [NUM_REGS];

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      for (int k = 0; k < NUM_REGS; k++) bank_q[k] <= '0;
    end else begin
      for (int k = 0; k < NUM_REGS; k++) begin
        if (regWr && (offset == 4'(k))) bank_q[k] <= DOUT;
      end
    end
  end

  always_comb begin
    REG_Q = '0;
    for (int k = 0; k < NUM_REGS; k++) REG_Q[k*DATA_W +: DATA_W] = bank_q[k];
  end

  logic [DATA_W-1:0] load_q,    load_d;
  logic [DATA_W-1:0] count_q,   count_d;
  logic [1:0]        ctrl_q,    ctrl_d;
  logic [PW-1:0]     presc_q,   presc_d;
  logic              run_q,     run_d;
  logic              expired_q, expired_d;
  logic              tick;
  logic              expire;

  // Priority is deliberate: an expiry beats a STATUS clear, and a LOAD write
  // beats the tick for count while the expiry still marks expired.
  always_comb begin
    load_d    = load_q;
    count_d   = count_q;
    ctrl_d    = ctrl_q;
    presc_d   = presc_q;
    run_d     = run_q;
    expired_d = expired_q;
    tick      = 1'b0;
    expire    = 1'b0;

    if (ctrl_q[0] && run_q) begin
      if (presc_q == PW'(PRESCALE - 1)) begin
        presc_d = '0;
        tick    = 1'b1;
      end else begin
        presc_d = presc_q + PW'(1);
      end
    end

    if (tick && (count_q != '0)) begin
      if (count_q == DATA_W'(1)) begin
        expire = 1'b1;
        if (ctrl_q[1]) begin
          count_d = load_q;
        end else begin
          count_d = '0;
          run_d   = 1'b0;
        end
      end else begin
        count_d = count_q - DATA_W'(1);
      end
    end

    if (tmrWr && (offset == 4'd2) && DOUT[0]) expired_d = 1'b0;
    if (expire) expired_d = 1'b1;

    if (tmrWr && (offset == 4'd1)) ctrl_d = DOUT[1:0];

    if (tmrWr && (offset == 4'd0)) begin
      load_d  = DOUT;
      count_d = DOUT;
      presc_d = '0;
      run_d   = 1'b1;
    end
  end

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      load_q    <= '0;
      count_q   <= '0;
      ctrl_q    <= '0;
      presc_q   <= '0;
      run_q     <= 1'b0;
      expired_q <= 1'b0;
    end else begin
      load_q    <= load_d;
      count_q   <= count_d;
      ctrl_q    <= ctrl_d;
      presc_q   <= presc_d;
      run_q     <= run_d;
      expired_q <= expired_d;
    end
  end

  assign TMR_IRQ = expired_q;

  logic [DATA_W-1:0] sync1_q;
  logic [DATA_W-1:0] swS_q;
  logic [DATA_W-1:0] swEdge_q, swEdge_d;
  logic [DATA_W-1:0] swRise;
  logic [DATA_W-1:0] swClr;

  // The rise is seen one stage early so the edge bit lands with sw_s itself.
  assign swRise = sync1_q & ~swS_q;
  assign swClr  = (swWr && (offset == 4'd1)) ? DOUT : '0;

  always_comb begin
    swEdge_d = (swEdge_q & ~swClr) | swRise;
  end

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      sync1_q  <= '0;
      swS_q    <= '0;
      swEdge_q <= '0;
    end else begin
      sync1_q  <= SW_IN;
      swS_q    <= sync1_q;
      swEdge_q <= swEdge_d;
    end
  end

  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              hit_q,   hit_d;

  always_comb begin
    rdata_d = '0;
    hit_d   = 1'b0;
    if (region == BASE_REG) begin
      hit_d = 1'b1;
      for (int k = 0; k < NUM_REGS; k++) begin
        if (offset == 4'(k)) rdata_d = bank_q[k];
      end
    end else if (region == BASE_TMR) begin
      hit_d = 1'b1;
      case (offset)
        4'd0:    rdata_d = load_q;
        4'd1:    rdata_d[1:0] = ctrl_q;
        4'd2:    rdata_d[0] = expired_q;
        4'd3:    rdata_d = count_q;
        default: rdata_d = '0;
      endcase
    end else if (region == BASE_SW) begin
      hit_d = 1'b1;
      case (offset)
        4'd0:    rdata_d = swS_q;
        4'd1:    rdata_d = swEdge_q;
        default: rdata_d = '0;
      endcase
    end
  end

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      rdata_q <= '0;
      hit_q   <= 1'b0;
    end else begin
      rdata_q <= rdata_d;
      hit_q   <= hit_d;
    end
  end

  assign RDATA = rdata_q;
  assign HIT   = hit_q;

endmodule

// File: tb/tb_mmio_periph_bank.sv
// Directed bench for mmio_periph_bank: one instance at PRESCALE=1 and one at
// PRESCALE=4 share the bus; inputs change on the falling edge, outputs sampled there.
module tb_mmio_periph_bank;

  logic        Clock;
  logic        Resetn;
  logic [15:0] ADDR;
  logic [15:0] DOUT;
  logic        W;
  logic [15:0] SW_IN;
  logic [15:0] rdata, rdata4;
  logic        hit, hit4;
  logic [63:0] regQ, regQ4;
  logic        tmrIrq, tmrIrq4;

  int nCompared   = 0;
  int nMismatched = 0;

  mmio_periph_bank #(.PRESCALE(1)) dut (
    .Clock(Clock), .Resetn(Resetn), .ADDR(ADDR), .DOUT(DOUT), .W(W), .SW_IN(SW_IN),
    .RDATA(rdata), .HIT(hit), .REG_Q(regQ), .TMR_IRQ(tmrIrq)
  );

  mmio_periph_bank #(.PRESCALE(4)) dut4 (
    .Clock(Clock), .Resetn(Resetn), .ADDR(ADDR), .DOUT(DOUT), .W(W), .SW_IN(SW_IN),
    .RDATA(rdata4), .HIT(hit4), .REG_Q(regQ4), .TMR_IRQ(tmrIrq4)
  );

  initial begin
    Clock = 1'b0;
    forever #5 Clock = ~Clock;
  end

  task automatic busWrite(input logic [15:0] a, input logic [15:0] d);
    ADDR = a;
    DOUT = d;
    W    = 1'b1;
    @(negedge Clock);
    W    = 1'b0;
  endtask

  task automatic busRead(input logic [15:0] a);
    ADDR = a;
    W    = 1'b0;
    @(negedge Clock);
  endtask

  task automatic test_reset();
    Resetn = 1'b0;
    @(negedge Clock);
    nCompared++;
    if (regQ !== 64'h0) begin nMismatched++; $display("[TB] FAIL reset_regq: got %h expected 0", regQ); end
    nCompared++;
    if (rdata !== 16'h0) begin nMismatched++; $display("[TB] FAIL reset_rdata: got %h expected 0", rdata); end
    nCompared++;
    if (hit !== 1'b0) begin nMismatched++; $display("[TB] FAIL reset_hit: got %b expected 0", hit); end
    nCompared++;
    if (tmrIrq !== 1'b0) begin nMismatched++; $display("[TB] FAIL reset_irq: got %b expected 0", tmrIrq); end
    Resetn = 1'b1;
    @(negedge Clock);
  endtask

  task automatic test_bank();
    busWrite(16'h1000, 16'h1234);
    nCompared++;
    if (regQ[15:0] !== 16'h1234) begin nMismatched++; $display("[TB] FAIL bank_regq0: got %h expected 1234", regQ[15:0]); end
    busRead(16'h1000);
    nCompared++;
    if (rdata !== 16'h1234) begin nMismatched++; $display("[TB] FAIL bank_read0: got %h expected 1234", rdata); end
    nCompared++;
    if (hit !== 1'b1) begin nMismatched++; $display("[TB] FAIL bank_hit0: got %b expected 1", hit); end
    busWrite(16'h1003, 16'hBEEF);
    busRead(16'h1003);
    nCompared++;
    if (rdata !== 16'hBEEF) begin nMismatched++; $display("[TB] FAIL bank_read3: got %h expected beef", rdata); end
    busRead(16'h1007);
    nCompared++;
    if (rdata !== 16'h0 || hit !== 1'b1) begin nMismatched++; $display("[TB] FAIL bank_unmapped_off: got %h/%b expected 0/1", rdata, hit); end
    busRead(16'h0005);
    nCompared++;
    if (rdata !== 16'h0 || hit !== 1'b0) begin nMismatched++; $display("[TB] FAIL region0: got %h/%b expected 0/0", rdata, hit); end
    busRead(16'h9000);
    nCompared++;
    if (rdata !== 16'h0 || hit !== 1'b0) begin nMismatched++; $display("[TB] FAIL region9: got %h/%b expected 0/0", rdata, hit); end
    busWrite(16'h1004, 16'hFFFF);
    nCompared++;
    if (regQ !== 64'hBEEF_0000_0000_1234) begin nMismatched++; $display("[TB] FAIL bank_oob_write: got %h expected beef000000001234", regQ); end
  endtask

  task automatic test_timer();
    busWrite(16'h3001, 16'h0001);
    busRead(16'h3001);
    nCompared++;
    if (rdata !== 16'h0001) begin nMismatched++; $display("[TB] FAIL tmr_ctrl_read: got %h expected 0001", rdata); end
    ADDR = 16'h3000; DOUT = 16'd5; W = 1'b1;
    @(negedge Clock);
    W = 1'b0; ADDR = 16'h3003;
    for (int i = 0; i < 5; i++) begin
      @(negedge Clock);
      nCompared++;
      if (rdata !== 16'(5 - i)) begin nMismatched++; $display("[TB] FAIL tmr_count[%0d]: got %0d expected %0d", i, rdata, 5 - i); end
      nCompared++;
      if (tmrIrq !== (i == 4)) begin nMismatched++; $display("[TB] FAIL tmr_irq[%0d]: got %b expected %b", i, tmrIrq, (i == 4)); end
    end
    repeat (3) @(negedge Clock);
    nCompared++;
    if (rdata !== 16'h0 || tmrIrq !== 1'b1) begin nMismatched++; $display("[TB] FAIL tmr_after: got %h/%b expected 0/1", rdata, tmrIrq); end
    busWrite(16'h3002, 16'h0001);
    nCompared++;
    if (tmrIrq !== 1'b0) begin nMismatched++; $display("[TB] FAIL tmr_clear: got %b expected 0", tmrIrq); end
    busWrite(16'h3000, 16'h0000);
    repeat (6) @(negedge Clock);
    nCompared++;
    if (tmrIrq !== 1'b0) begin nMismatched++; $display("[TB] FAIL tmr_load0: got %b expected 0", tmrIrq); end
  endtask

  task automatic test_prescale();
    logic        expIrq;
    logic [15:0] expCount;
    Resetn = 1'b0;
    @(negedge Clock);
    Resetn = 1'b1;
    busWrite(16'h3001, 16'h0003);
    ADDR = 16'h3000; DOUT = 16'd2; W = 1'b1;
    @(negedge Clock);
    for (int c = 1; c <= 24; c++) begin
      if (c == 12 || c == 16) begin
        ADDR = 16'h3002; DOUT = 16'h0001; W = 1'b1;
      end else begin
        ADDR = 16'h3003; W = 1'b0;
      end
      @(negedge Clock);
      expIrq   = ((c >= 8) && (c < 12)) || (c >= 16);
      expCount = (((c - 1) % 8) < 4) ? 16'd2 : 16'd1;
      nCompared++;
      if (tmrIrq4 !== expIrq) begin nMismatched++; $display("[TB] FAIL pre_irq[%0d]: got %b expected %b", c, tmrIrq4, expIrq); end
      if (c != 12 && c != 16) begin
        nCompared++;
        if (rdata4 !== expCount) begin nMismatched++; $display("[TB] FAIL pre_count[%0d]: got %0d expected %0d", c, rdata4, expCount); end
      end
    end
    W = 1'b0;
  endtask

  task automatic test_switch();
    ADDR = 16'h4000;
    SW_IN = 16'h0008;
    @(negedge Clock);
    @(negedge Clock);
    nCompared++;
    if (rdata !== 16'h0) begin nMismatched++; $display("[TB] FAIL sw_sync_early: got %h expected 0", rdata); end
    @(negedge Clock);
    nCompared++;
    if (rdata !== 16'h0008) begin nMismatched++; $display("[TB] FAIL sw_sync: got %h expected 0008", rdata); end
    busRead(16'h4001);
    nCompared++;
    if (rdata !== 16'h0008) begin nMismatched++; $display("[TB] FAIL sw_edge: got %h expected 0008", rdata); end
    busWrite(16'h4000, 16'hFFFF);
    busRead(16'h4000);
    nCompared++;
    if (rdata !== 16'h0008) begin nMismatched++; $display("[TB] FAIL sw_ro: got %h expected 0008", rdata); end
    busWrite(16'h4001, 16'h0008);
    busRead(16'h4001);
    nCompared++;
    if (rdata !== 16'h0) begin nMismatched++; $display("[TB] FAIL sw_edge_clear: got %h expected 0", rdata); end
    SW_IN = 16'h0000;
    repeat (4) @(negedge Clock);
    busRead(16'h4001);
    nCompared++;
    if (rdata !== 16'h0) begin nMismatched++; $display("[TB] FAIL sw_fall: got %h expected 0", rdata); end
    SW_IN = 16'h0008;
    @(negedge Clock);
    busWrite(16'h4001, 16'h0008);
    busRead(16'h4001);
    nCompared++;
    if (rdata !== 16'h0008) begin nMismatched++; $display("[TB] FAIL sw_edge_race: got %h expected 0008", rdata); end
  endtask

  task automatic test_reset_midcount();
    busWrite(16'h1000, 16'h55AA);
    busWrite(16'h3001, 16'h0001);
    busWrite(16'h3000, 16'd100);
    ADDR = 16'h1000;
    repeat (10) @(negedge Clock);
    #2 Resetn = 1'b0;
    #1;
    nCompared++;
    if (regQ !== 64'h0 || rdata !== 16'h0 || hit !== 1'b0 || tmrIrq !== 1'b0) begin
      nMismatched++;
      $display("[TB] FAIL midreset_outputs: got regq=%h rdata=%h hit=%b irq=%b expected all 0", regQ, rdata, hit, tmrIrq);
    end
    @(negedge Clock);
    Resetn = 1'b1;
    busWrite(16'h3001, 16'h0001);
    ADDR = 16'h3003;
    repeat (110) @(negedge Clock);
    nCompared++;
    if (tmrIrq !== 1'b0) begin nMismatched++; $display("[TB] FAIL midreset_noexpiry: got %b expected 0", tmrIrq); end
    nCompared++;
    if (rdata !== 16'h0) begin nMismatched++; $display("[TB] FAIL midreset_count: got %h expected 0", rdata); end
  endtask

  initial begin
    Resetn = 1'b0;
    ADDR   = 16'h0;
    DOUT   = 16'h0;
    W      = 1'b0;
    SW_IN  = 16'h0;
    @(negedge Clock);
    test_reset();
    test_bank();
    test_timer();
    test_prescale();
    test_switch();
    test_reset_midcount();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
